alu_share_arb: RTL

Two-requester arbiter and sequencer that shares one `alu` instance between two clients, for example the main execute path and an address/branch-compare unit. It accepts one operation at a time by round-robin grant and registers the operands. It applies RISC-V shift-amount masking, evaluates the ALU, and returns a registered result over a valid/ready handshake. Each operation takes three cycles from grant to response.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 35 +++
 rtl/alu_share_arb.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-client sharing arbiter:
// ALU control codes, sequencer state encoding and an op classifier.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the ops whose b operand is a shift amount.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Shift amounts are used as given; callers that want
// RISC-V semantics mask b before it arrives here. Undefined codes give 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Select the operation result for the current control code.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  result = a << b;
            ALU_XOR:  result = a ^ b;
            ALU_SRA:  result = $unsigned($signed(a) >>> b);
            ALU_SRL:  result = a >> b;
            default:  result = {WIDTH{1'b0}};
        endcase
    end

    assign zero = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters. One operation in flight at a time:
// round-robin grant in IDLE, evaluate in EXEC, hold the registered result
// in RESP until the owning requester takes it.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,
    output logic             rsp0_sltu,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,
    output logic             rsp1_sltu
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_grant_r;
    logic             gnt_idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_zero_r;
    logic             rsp_sltu_r;
    logic [1:0]       rsp_valid_r;

    logic             gnt_any_s;
    logic             gnt_idx_s;
    logic             rsp_hs_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] alu_out_s;
    logic             alu_zero_s;
    logic             sltu_s;

    // Round-robin pick: a tie goes to the requester not granted last time.
    always_comb begin
        gnt_idx_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_idx_s = ~last_grant_r;
        end else if (req1_valid) begin
            gnt_idx_s = 1'b1;
        end else begin
            gnt_idx_s = 1'b0;
        end
    end

    assign gnt_any_s = (state_r == ST_IDLE) && (req0_valid || req1_valid);

    // Ready is gated by reset so it drops without waiting for a clock edge.
    assign req0_ready = gnt_any_s && (gnt_idx_s == 1'b0) && !reset;
    assign req1_ready = gnt_any_s && (gnt_idx_s == 1'b1) && !reset;

    assign rsp_hs_s = (rsp_valid_r[0] && rsp0_ready) || (rsp_valid_r[1] && rsp1_ready);

    // Shift ops only see the low log2(WIDTH) bits of b, zero-extended.
    always_comb begin
        b_eff_s = b_r;
        if (is_shift_op(op_r)) begin
            b_eff_s = {{(WIDTH-SH_W){1'b0}}, b_r[SH_W-1:0]};
        end else begin
            b_eff_s = b_r;
        end
    end

    assign sltu_s = (a_r < b_eff_s);

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_r),
        .a      (a_r),
        .b      (b_eff_s),
        .result (alu_out_s),
        .zero   (alu_zero_s)
    );

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on grant, result capture in EXEC, valid flag per requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            gnt_idx_r    <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            op_r         <= 4'b0000;
            rsp_data_r   <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_sltu_r   <= 1'b0;
            rsp_valid_r  <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_any_s) begin
                        last_grant_r <= gnt_idx_s;
                        gnt_idx_r    <= gnt_idx_s;
                        a_r          <= gnt_idx_s ? req1_a  : req0_a;
                        b_r          <= gnt_idx_s ? req1_b  : req0_b;
                        op_r         <= gnt_idx_s ? req1_op : req0_op;
                    end
                end
                ST_EXEC: begin
                    rsp_data_r             <= alu_out_s;
                    rsp_zero_r             <= alu_zero_s;
                    rsp_sltu_r             <= sltu_s;
                    rsp_valid_r[gnt_idx_r] <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= 2'b00;
                    end
                end
                default: rsp_valid_r <= 2'b00;
            endcase
        end
    end

    assign rsp0_valid = rsp_valid_r[0];
    assign rsp1_valid = rsp_valid_r[1];
    assign rsp0_data  = rsp_data_r;
    assign rsp1_data  = rsp_data_r;
    assign rsp0_zero  = rsp_zero_r;
    assign rsp1_zero  = rsp_zero_r;
    assign rsp0_sltu  = rsp_sltu_r;
    assign rsp1_sltu  = rsp_sltu_r;

endmodule
